// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Segment buses are ordered {a,b,c,d,e,f,g}: bit 6 = a ... bit 0 = g.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;   // {a,b,c,d,e,f,g}

  localparam seg_t             SEG_OFF = 7'h7F;  // all segments dark (active-low)
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;  // all anodes off (active-low)

  // Registered display word driven onto the pins.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an_n;
    seg_t                  seg_n;
    logic                  dp_n;
  } disp_t;

  localparam disp_t DISP_OFF = '{an_n: AN_OFF, seg_n: SEG_OFF, dp_n: 1'b1};

endpackage

// File: rtl/bcdtosevensegment.sv
// BCD to seven-segment decoder, active-high outputs.
//   bcd_i : BCD digit (values above 9 decode to all segments off)
//   seg_o : segments {a,b,c,d,e,f,g}, 1 = lit
module bcdtosevensegment
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  always_comb begin
    unique case (bcd_i)
      4'd0:    seg_o = 7'b1111110;
      4'd1:    seg_o = 7'b0110000;
      4'd2:    seg_o = 7'b1101101;
      4'd3:    seg_o = 7'b1111001;
      4'd4:    seg_o = 7'b0110011;
      4'd5:    seg_o = 7'b1011011;
      4'd6:    seg_o = 7'b1011111;
      4'd7:    seg_o = 7'b1110000;
      4'd8:    seg_o = 7'b1111111;
      4'd9:    seg_o = 7'b1111011;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Scans four BCD digits onto one shared segment bus with a dead time at the
// start of each slot, optional leading-zero blanking and a per-frame input
// snapshot so a displayed frame never mixes two input values.
//   clk, rst_n  : clock, async active-low reset
//   en          : scan enable; low clears the scan position
//   digits      : four BCD digits, [3:0] = rightmost
//   dp_in       : decimal-point request per digit
//   lz_blank    : leading-zero blanking enable
//   an_n        : anode enables, active-low
//   seg_n       : segments {a..g}, active-low
//   dp_n        : decimal point, active-low
//   frame_tick  : one-cycle pulse after the last cycle of each frame
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      lz_blank,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic                      frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W:0]   BLANK_N = (CNT_W + 1)'(BLANK_CYCLES);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   sh_dig_q;
  logic [NUM_DIGITS-1:0]     sh_dp_q;
  logic                      sh_lz_q;
  disp_t                     disp_q, disp_d;
  logic                      tick_q, tick_d;

  // The snapshot edge is also the first output edge of the frame, so the
  // incoming values are used directly there (matters when BLANK_CYCLES=0).
  logic                      cap;
  logic [4*NUM_DIGITS-1:0]   view_dig;
  logic [NUM_DIGITS-1:0]     view_dp;
  logic                      view_lz;

  assign cap      = en && (idx_q == 2'd0) && (cnt_q == '0);
  assign view_dig = cap ? digits   : sh_dig_q;
  assign view_dp  = cap ? dp_in    : sh_dp_q;
  assign view_lz  = cap ? lz_blank : sh_lz_q;

  logic [3:0] cur_dig;
  seg_t       seg_dec;
  assign cur_dig = view_dig[4*idx_q +: 4];

  bcdtosevensegment u_dec (
    .bcd_i (cur_dig),
    .seg_o (seg_dec)
  );

  // lead_zero[k]: digit k and every digit above it are zero. Digit 0 never
  // qualifies so an all-zero value still shows "0".
  logic [NUM_DIGITS-1:0] lead_zero;
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run          = run && (view_dig[4*k +: 4] == 4'd0);
      lead_zero[k] = run;
    end
  end

  logic dead, blanked, dp_req;
  assign dead    = ({1'b0, cnt_q} < BLANK_N);
  assign blanked = (cur_dig > 4'd9) || (view_lz && lead_zero[idx_q]);
  assign dp_req  = view_dp[idx_q];

  always_comb begin
    disp_d = DISP_OFF;
    if (en && !dead) begin
      if (!blanked) begin
        disp_d.an_n  = ~(4'b0001 << idx_q);
        disp_d.seg_n = ~seg_dec;
        disp_d.dp_n  = ~dp_req;
      end else if (dp_req) begin
        // Blanked digit with a decimal point: anode on for the dp only.
        disp_d.an_n  = ~(4'b0001 << idx_q);
        disp_d.dp_n  = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d  = '0;
    idx_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      idx_d  = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
      tick_d = (idx_q == 2'd3) && (cnt_q == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_lz_q  <= 1'b0;
      disp_q   <= DISP_OFF;
      tick_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      tick_q <= tick_d;
      if (cap) begin
        sh_dig_q <= digits;
        sh_dp_q  <= dp_in;
        sh_lz_q  <= lz_blank;
      end
    end
  end

  assign an_n       = disp_q.an_n;
  assign seg_n      = disp_q.seg_n;
  assign dp_n       = disp_q.dp_n;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench: a behavioural model pushes the expected display word for
// every enabled edge; a monitor pops and compares on the falling edge.
// Two instances: CLK_DIV=8/BLANK_CYCLES=2 and CLK_DIV=2/BLANK_CYCLES=0.
module tb_sevenseg_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  localparam exp_t RST = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};

  logic        clk, rst_n, en, lz_blank;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, ft0, ft1;

  sevenseg_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .lz_blank(lz_blank), .an_n(an0), .seg_n(seg0), .dp_n(dp0), .frame_tick(ft0));

  sevenseg_scan_driver #(.CLK_DIV(2), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .lz_blank(lz_blank), .an_n(an1), .seg_n(seg1), .dp_n(dp1), .frame_tick(ft1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input exp_t got, input exp_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
               name, got.an, got.seg, got.dp, got.tick, exp.an, exp.seg, exp.dp, exp.tick);
    end
  endtask

  // Active-high {a..g} patterns for 0..9.
  logic [6:0] SEGTAB [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  // Reference model: position within the frame and the frame's snapshot.
  int          cd [2] = '{8, 2};
  int          bc [2] = '{2, 0};
  int          pos [2];
  logic [15:0] sd [2];
  logic [3:0]  sdp [2];
  logic        slz [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
          pos[k] = 0; sd[k] = '0; sdp[k] = '0; slz[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          exp_t       e;
          int         i, c, d;
          logic       blank, dpon;
          logic [3:0] one;
          one = 4'b0001;
          e   = RST;
          if (en) begin
            if (pos[k] == 0) begin
              sd[k] = digits; sdp[k] = dp_in; slz[k] = lz_blank;
            end
            i     = pos[k] / cd[k];
            c     = pos[k] % cd[k];
            d     = int'((sd[k] >> (4 * i)) & 16'hF);
            blank = (d > 9) || (slz[k] && i > 0 && (sd[k] >> (4 * i)) == 16'h0);
            dpon  = sdp[k][i];
            if (c >= bc[k]) begin
              if (!blank) begin
                e.an = ~(one << i); e.seg = ~SEGTAB[d]; e.dp = !dpon;
              end else if (dpon) begin
                e.an = ~(one << i); e.dp = 1'b0;
              end
            end
            e.tick = (pos[k] == 4 * cd[k] - 1);
            pos[k] = (pos[k] + 1) % (4 * cd[k]);
          end else begin
            pos[k] = 0;
          end
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
  end

  // Monitor: one expected word per instance per cycle while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset0", {an0, seg0, dp0, ft0}, RST);
        chk("reset1", {an1, seg1, dp1, ft1}, RST);
      end else begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard0: got empty queue, want an entry");
        end else chk("scan0", {an0, seg0, dp0, ft0}, q0.pop_front());
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard1: got empty queue, want an entry");
        end else chk("scan1", {an1, seg1, dp1, ft1}, q1.pop_front());
        n_cmp++;
        if ($countones(~an1) > 1) begin
          n_bad++;
          $display("FAIL one_anode1: got an_n=%b, want at most one low", an1);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic realign();
    en = 1'b0;
    wait_cyc(1);
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; digits = '0; dp_in = '0; lz_blank = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1; en = 1'b1; digits = 16'h1234;
    wait_cyc(64);
    // Mid-slot asynchronous reset: outputs must drop before any clock edge.
    wait_cyc(5);
    rst_n = 1'b0;
    #1;
    chk("async_rst0", {an0, seg0, dp0, ft0}, RST);
    chk("async_rst1", {an1, seg1, dp1, ft1}, RST);
    wait_cyc(2);
    rst_n = 1'b1;
    digits = 16'h0050; lz_blank = 1'b1;
    wait_cyc(96);
    digits = 16'h0000;
    wait_cyc(64);
    // Snapshot coherence: change inputs during slot 2 of a known frame.
    lz_blank = 1'b0;
    realign();
    digits = 16'h8888;
    wait_cyc(52);
    digits = 16'h1111;
    wait_cyc(40);
    // Invalid digit with decimal point.
    digits = 16'h123C; dp_in = 4'b0001;
    wait_cyc(64);
    // Enable drop in slot 2, then restart with a new value.
    dp_in = 4'b0000;
    realign();
    wait_cyc(19);
    en = 1'b0;
    wait_cyc(5);
    digits = 16'h4321; en = 1'b1;
    wait_cyc(64);
    // Randomized stream.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 29) == 0) begin
        logic [15:0] v;
        for (int n = 0; n < 4; n++)
          v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        digits = v;
      end
      if ($urandom_range(0, 39) == 0) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lz_blank = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 59) != 0);
      wait_cyc(1);
    end
    en = 1'b1;
    wait_cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
